fetch_unit: RTL and testbench

Instruction fetch unit; the consumer of the program-counter address stream. Accepts fetch addresses from the PC stage over a valid/ready handshake, issues one read at a time to instruction memory over a req/ack bus, and buffers returned instructions with their PC in a small FIFO for decode. A redirect flush (taken branch/jump) discards buffered and in-flight fetches.

---
 rtl/fetch_pkg.sv | 24 ++
 rtl/fetch_fifo.sv | 58 +++++
 rtl/fetch_unit.sv | 119 +++++++++++
 tb/tb_fetch_unit.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types for the instruction fetch unit.
//   fetch_state_t : fetch FSM state (IDLE, BUSY, DROP)
//   fetch_entry_t : one buffered fetch result {instr, pc, misaligned}
//   NOP_INSTR     : instruction substituted for misaligned fetches
package fetch_pkg;

    localparam int INSTR_W = 32;
    localparam int PC_W    = 32;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DROP
    } fetch_state_t;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
        logic               misaligned;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: show-ahead FIFO of fetch_entry_t for the decode stage.
//   clk, rst   : clock, synchronous active-low reset
//   clear      : synchronous flush, empties the FIFO (wins over push/pop)
//   push/wdata : write one entry (ignored when full)
//   pop        : drop the head entry (ignored when empty)
//   head       : current head entry, all zero when empty
//   count      : number of stored entries (0..DEPTH)
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          push,
    input  fetch_entry_t  wdata,
    input  logic          pop,
    output fetch_entry_t  head,
    output logic [CW-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    fetch_entry_t  mem [DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic          do_push;
    logic          do_pop;

    assign do_push = push && (count < FULL);
    assign do_pop  = pop && (count != '0);

    // Pointers are log2(DEPTH) bits wide, so they wrap on their own.
    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                mem[wptr] <= wdata;
                wptr      <= wptr + 1'b1;
            end
            if (do_pop)
                rptr <= rptr + 1'b1;
            if (do_push && !do_pop)
                count <= count + 1'b1;
            else if (!do_push && do_pop)
                count <= count - 1'b1;
        end
    end

    assign head = (count != '0) ? mem[rptr] : '0;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch between the PC stage and decode.
//   clk, rst                      : clock, synchronous active-low reset
//   pc_addr/pc_valid/pc_ready     : fetch address handshake from the PC stage
//   flush                         : redirect; drops buffered and in-flight fetches
//   imem_req/imem_addr            : one outstanding read, held until imem_ack
//   imem_ack/imem_rdata           : read completion and data
//   instr/instr_pc/instr_misaligned/instr_valid/instr_ready : FIFO head to decode
// DATA_WIDTH/ADDR_WIDTH must match the widths of fetch_entry_t in fetch_pkg.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int DATA_WIDTH = INSTR_W,
    parameter int ADDR_WIDTH = PC_W,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] pc_addr,
    input  logic                  pc_valid,
    output logic                  pc_ready,
    input  logic                  flush,
    output logic                  imem_req,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic                  imem_ack,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    output logic                  instr_misaligned,
    output logic                  instr_valid,
    input  logic                  instr_ready
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    fetch_state_t  state;
    fetch_entry_t  push_entry;
    fetch_entry_t  head;
    logic          push;
    logic          accept;
    logic          aligned;
    logic [CW-1:0] count;

    // Space is checked at accept time; with only one fetch outstanding the
    // later push can never find the FIFO full.
    assign pc_ready = (state == IDLE) && (count < FULL) && !flush && rst;
    assign accept   = pc_valid && pc_ready;
    assign aligned  = (pc_addr[1:0] == 2'b00);

    always_comb begin
        push       = 1'b0;
        push_entry = '0;
        if (accept && !aligned) begin
            // Misaligned fetch never reaches memory; decode sees a flagged NOP.
            push       = 1'b1;
            push_entry = '{instr: NOP_INSTR, pc: pc_addr, misaligned: 1'b1};
        end else if (state == BUSY && imem_ack && !flush) begin
            push       = 1'b1;
            push_entry = '{instr: imem_rdata, pc: imem_addr, misaligned: 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            imem_req  <= 1'b0;
            imem_addr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept && aligned) begin
                        imem_addr <= pc_addr;
                        imem_req  <= 1'b1;
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    if (imem_ack) begin
                        imem_req <= 1'b0;
                        state    <= IDLE;
                    end else if (flush) begin
                        // The bus read cannot be cancelled; wait it out in DROP.
                        state <= DROP;
                    end
                end
                DROP: begin
                    if (imem_ack) begin
                        imem_req <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: begin
                    imem_req <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clear (flush),
        .push  (push),
        .wdata (push_entry),
        .pop   (instr_ready),
        .head  (head),
        .count (count)
    );

    assign instr            = head.instr;
    assign instr_pc         = head.pc;
    assign instr_misaligned = head.misaligned;
    assign instr_valid      = (count != '0);

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_addr;
    logic        pc_valid;
    logic        pc_ready;
    logic        flush;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_misaligned;
    logic        instr_valid;
    logic        instr_ready;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    fetch_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(4)) dut (
        .clk              (clk),
        .rst              (rst),
        .pc_addr          (pc_addr),
        .pc_valid         (pc_valid),
        .pc_ready         (pc_ready),
        .flush            (flush),
        .imem_req         (imem_req),
        .imem_addr        (imem_addr),
        .imem_ack         (imem_ack),
        .imem_rdata       (imem_rdata),
        .instr            (instr),
        .instr_pc         (instr_pc),
        .instr_misaligned (instr_misaligned),
        .instr_valid      (instr_valid),
        .instr_ready      (instr_ready)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are driven here.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Zero-wait fetch: accept on the next edge, ack in the first request cycle.
    task automatic zw_fetch(input logic [31:0] a, input logic [31:0] d);
        pc_valid = 1'b1;
        pc_addr  = a;
        cyc();
        pc_valid   = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = d;
        #2;
        check("zw_req", imem_req, 1);
        check("zw_addr", imem_addr, a);
        cyc();
        imem_ack = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] exp_pc [4];
        exp_pc = '{32'h4, 32'h8, 32'hC, 32'h10};

        rst = 1'b0; pc_valid = 1'b1; pc_addr = 32'h0; flush = 1'b0;
        imem_ack = 1'b0; imem_rdata = 32'h0; instr_ready = 1'b0;

        // ---- reset ----
        cyc(); #2;
        check("rst_pc_ready", pc_ready, 0);
        check("rst_req", imem_req, 0);
        check("rst_addr", imem_addr, 0);
        check("rst_valid", instr_valid, 0);
        check("rst_instr", instr, 0);
        check("rst_instr_pc", instr_pc, 0);
        check("rst_mis", instr_misaligned, 0);
        cyc();
        rst = 1'b1; pc_valid = 1'b0;
        #2;
        check("rel_pc_ready", pc_ready, 1);

        // ---- single fetch, ack 3 cycles after req ----
        pc_valid = 1'b1; pc_addr = 32'h4;
        cyc();
        pc_valid = 1'b0;
        #2;
        check("sf_req", imem_req, 1);
        check("sf_addr", imem_addr, 32'h4);
        check("sf_busy_ready", pc_ready, 0);
        cyc(); cyc(); cyc();
        check("sf_req_held", imem_req, 1);
        check("sf_addr_held", imem_addr, 32'h4);
        check("sf_not_yet", instr_valid, 0);
        imem_ack = 1'b1; imem_rdata = 32'h0050_0093;
        cyc();
        imem_ack = 1'b0;
        #2;
        check("sf_valid", instr_valid, 1);
        check("sf_instr", instr, 32'h0050_0093);
        check("sf_pc", instr_pc, 32'h4);
        check("sf_mis", instr_misaligned, 0);
        check("sf_req_drop", imem_req, 0);
        check("sf_ready", pc_ready, 1);
        instr_ready = 1'b1;
        cyc();
        instr_ready = 1'b0;
        #2;
        check("sf_popped", instr_valid, 0);
        check("sf_empty_instr", instr, 0);

        // ---- fill with decode stalled ----
        zw_fetch(32'h0,  32'hA000_0000);
        zw_fetch(32'h4,  32'hA000_0004);
        zw_fetch(32'h8,  32'hA000_0008);
        zw_fetch(32'hC,  32'hA000_000C);
        pc_valid = 1'b1; pc_addr = 32'h10;
        #2;
        check("fill_full_ready", pc_ready, 0);
        check("fill_head_pc", instr_pc, 32'h0);
        check("fill_head_instr", instr, 32'hA000_0000);
        cyc(); #2;
        check("fill_no_req", imem_req, 0);
        instr_ready = 1'b1;
        cyc();
        instr_ready = 1'b0;
        #2;
        check("fill_after_pop_pc", instr_pc, 32'h4);
        check("fill_after_pop_ready", pc_ready, 1);
        cyc();
        pc_valid = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hA000_0010;
        #2;
        check("fill_10_req", imem_req, 1);
        check("fill_10_addr", imem_addr, 32'h10);
        cyc();
        imem_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #2;
            check("fill_order_pc", instr_pc, exp_pc[i]);
            check("fill_order_instr", instr, 32'hA000_0000 | exp_pc[i]);
            instr_ready = 1'b1;
            cyc();
        end
        instr_ready = 1'b0;
        #2;
        check("fill_drained", instr_valid, 0);

        // ---- flush during BUSY, ack 2 cycles later ----
        pc_valid = 1'b1; pc_addr = 32'h20;
        cyc();
        pc_valid = 1'b0;
        #2;
        check("fb_req", imem_req, 1);
        flush = 1'b1;
        #2;
        check("fb_flush_ready", pc_ready, 0);
        cyc();
        flush = 1'b0;
        #2;
        check("fb_drop_req", imem_req, 1);
        check("fb_drop_ready", pc_ready, 0);
        cyc();
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        #2;
        check("fb_ack_ready", pc_ready, 0);
        cyc();
        imem_ack = 1'b0;
        #2;
        check("fb_req_done", imem_req, 0);
        check("fb_ready_back", pc_ready, 1);
        check("fb_no_data", instr_valid, 0);
        cyc(); #2;
        check("fb_still_empty", instr_valid, 0);

        // ---- flush and ack in the same cycle ----
        pc_valid = 1'b1; pc_addr = 32'h40;
        cyc();
        pc_valid = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h1111_1111; flush = 1'b1;
        cyc();
        imem_ack = 1'b0; flush = 1'b0;
        #2;
        check("fa_empty", instr_valid, 0);
        check("fa_req", imem_req, 0);
        check("fa_idle_ready", pc_ready, 1);

        // ---- flush with two buffered entries, pop in the same cycle ----
        zw_fetch(32'h50, 32'h5050_5050);
        zw_fetch(32'h54, 32'h5454_5454);
        #2;
        check("f2_buffered", instr_valid, 1);
        flush = 1'b1; instr_ready = 1'b1;
        cyc();
        flush = 1'b0; instr_ready = 1'b0;
        #2;
        check("f2_empty", instr_valid, 0);
        check("f2_instr_zero", instr, 0);
        check("f2_ready", pc_ready, 1);
        zw_fetch(32'h100, 32'h0010_0113);
        #2;
        check("f2_next_valid", instr_valid, 1);
        check("f2_next_pc", instr_pc, 32'h100);
        check("f2_next_instr", instr, 32'h0010_0113);
        instr_ready = 1'b1;
        cyc();
        #2;
        check("f2_single_entry", instr_valid, 0);
        // pop while empty must be ignored
        cyc();
        instr_ready = 1'b0;

        // ---- misaligned, then stray ack in IDLE ----
        pc_valid = 1'b1; pc_addr = 32'h6;
        cyc();
        pc_valid = 1'b0;
        #2;
        check("mis_no_req", imem_req, 0);
        check("mis_valid", instr_valid, 1);
        check("mis_instr", instr, 32'h0000_0013);
        check("mis_pc", instr_pc, 32'h6);
        check("mis_flag", instr_misaligned, 1);
        check("mis_ready", pc_ready, 1);
        imem_ack = 1'b1; imem_rdata = 32'hBAD0_BAD0; instr_ready = 1'b1;
        cyc();
        imem_ack = 1'b0; instr_ready = 1'b0;
        #2;
        check("stray_ack_ignored", instr_valid, 0);
        check("stray_no_req", imem_req, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
